// File: rtl/register_bank32_pkg.sv
// Shared sizes and sequencer state encoding for the 32-entry register bank.
package regbank_pkg;
    localparam int NREG  = 32;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FIN   = 2'd2
    } state_e;
endpackage

// File: rtl/register_bank32_if.sv
// Write port, clear handshake and the 32 parallel read outputs of the register bank.
interface register_bank32_if #(parameter int n = 8);
    import regbank_pkg::*;

    logic                      WE;
    logic [IDX_W-1:0]          WS;
    logic [n-1:0]              WD;
    logic                      CLR;
    logic                      BUSY;
    logic                      DONE;
    // R[i] is output Rxx for register i, wired straight to read mux input Ixx
    logic [NREG-1:0][n-1:0]    R;

    modport master (output WE, WS, WD, CLR, input BUSY, DONE, R);
    modport slave  (input WE, WS, WD, CLR, output BUSY, DONE, R);
endinterface

// File: rtl/register_bank32_decoder.sv
// 5-bit index to 32-bit one-hot enable decoder; purely combinational.
module Decoder5to32
    import regbank_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [NREG-1:0]  onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/register_bank32.sv
// 32 x n register bank with parallel read outputs, one synchronous write port and a
// one-register-per-cycle clear sweep; writes land after one edge, clear takes 33 cycles.
module register_bank32
    import regbank_pkg::*;
#(
    parameter int n       = 8,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    register_bank32_if.slave  bus
);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] p_q, p_d;
    logic [n-1:0]     regs_q [NREG];
    logic [n-1:0]     regs_d [NREG];

    logic             busy, done;
    logic             dec_en;
    logic [IDX_W-1:0] dec_idx;
    logic [NREG-1:0]  dec_hot;
    logic [n-1:0]     wr_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (bus.CLR) begin
                    state_d = SWEEP;
                    p_d     = '0;
                end
            end
            SWEEP: begin
                // end of sweep is an explicit compare, never pointer wrap
                if (p_q == IDX_W'(NREG - 1)) begin
                    state_d = FIN;
                    p_d     = '0;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: begin
                state_d = IDLE;
                p_d     = '0;
            end
        endcase
    end

    // one decoder serves both the write select and the sweep pointer
    always_comb begin
        busy    = (state_q == SWEEP);
        done    = (state_q == FIN);
        dec_en  = busy | ((state_q == IDLE) & bus.WE);
        dec_idx = busy ? p_q : bus.WS;
        wr_val  = busy ? '0 : bus.WD;
    end

    Decoder5to32 u_dec (
        .en     (dec_en),
        .idx    (dec_idx),
        .onehot (dec_hot)
    );

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (dec_hot[i] && !((ZERO_R0 != 0) && (i == 0))) regs_d[i] = wr_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        bus.BUSY = busy;
        bus.DONE = done;
        for (int i = 0; i < NREG; i++) begin
            bus.R[i] = ((ZERO_R0 != 0) && (i == 0)) ? '0 : regs_q[i];
        end
    end
endmodule

// File: tb/tb_register_bank32.sv
// Self-checking bench for register_bank32: two instances (ZERO_R0 = 1 and 0) driven identically.
module tb_register_bank32;
    import regbank_pkg::*;

    localparam int N = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_bank32_if #(.n(N)) ifa ();
    register_bank32_if #(.n(N)) ifb ();

    register_bank32 #(.n(N), .ZERO_R0(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    register_bank32 #(.n(N), .ZERO_R0(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int n_checks = 0;
    int n_errors = 0;

    // reference: register contents plus "clear edges still to come" and "in finish cycle"
    logic [N-1:0] m_a [NREG];
    logic [N-1:0] m_b [NREG];
    int           m_left;
    bit           m_fin;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        m_left = 0;
        m_fin  = 1'b0;
    endtask

    task automatic drive(input bit we, input logic [4:0] ws, input logic [N-1:0] wd, input bit clr);
        ifa.WE = we; ifa.WS = ws; ifa.WD = wd; ifa.CLR = clr;
        ifb.WE = we; ifb.WS = ws; ifb.WD = wd; ifb.CLR = clr;
    endtask

    // apply inputs from a falling edge, take one rising edge, return at the next falling edge
    task automatic step(input bit we, input logic [4:0] ws, input logic [N-1:0] wd, input bit clr);
        drive(we, ws, wd, clr);
        @(posedge clk);
        if (rst_n) begin
            if (m_left > 0) begin
                m_a[NREG - m_left] = '0;
                m_b[NREG - m_left] = '0;
                m_left--;
                if (m_left == 0) m_fin = 1'b1;
            end else if (m_fin) begin
                m_fin = 1'b0;
            end else begin
                if (we) begin
                    if (ws != 0) m_a[ws] = wd;
                    m_b[ws] = wd;
                end
                if (clr) m_left = NREG;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5'd9, 8'h99, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (ifa.BUSY !== 1'b0 || ifa.DONE !== 1'b0 || ifb.BUSY !== 1'b0 || ifb.DONE !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: busy=%b/%b done=%b/%b expected 0", ifa.BUSY, ifb.BUSY, ifa.DONE, ifb.DONE);
        end
        for (int i = 0; i < NREG; i++) begin
            n_checks++;
            if (ifa.R[i] !== '0 || ifb.R[i] !== '0) begin
                n_errors++;
                $display("FAIL reset_R%0d: got %h/%h expected 00", i, ifa.R[i], ifb.R[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        step(1'b1, 5'd5, 8'hA5, 1'b0);
        n_checks++;
        if (ifa.R[5] !== 8'hA5 || ifb.R[5] !== 8'hA5) begin
            n_errors++;
            $display("FAIL write_R05: got %h/%h expected a5", ifa.R[5], ifb.R[5]);
        end
        for (int i = 0; i < NREG; i++) begin
            if (i != 5) begin
                n_checks++;
                if (ifa.R[i] !== '0 || ifb.R[i] !== '0) begin
                    n_errors++;
                    $display("FAIL write_other_R%0d: got %h/%h expected 00", i, ifa.R[i], ifb.R[i]);
                end
            end
        end
    endtask

    task automatic test_r0_guard();
        step(1'b1, 5'd0, 8'hFF, 1'b0);
        n_checks++;
        if (ifa.R[0] !== 8'h00) begin
            n_errors++;
            $display("FAIL r0_guard_zero: got %h expected 00", ifa.R[0]);
        end
        n_checks++;
        if (ifb.R[0] !== 8'hFF) begin
            n_errors++;
            $display("FAIL r0_guard_open: got %h expected ff", ifb.R[0]);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < NREG; i++) step(1'b1, 5'(i), 8'(i + 1), 1'b0);
        step(1'b0, 5'd0, '0, 1'b1);
        n_checks++;
        if (ifa.BUSY !== 1'b1 || ifa.DONE !== 1'b0) begin
            n_errors++;
            $display("FAIL sweep_start: busy=%b done=%b expected 1 0", ifa.BUSY, ifa.DONE);
        end
        for (int j = 1; j <= 33; j++) begin
            step(1'b0, 5'd0, '0, 1'b0);
            n_checks++;
            if (ifa.BUSY !== (j < 32) || ifa.DONE !== (j == 32) ||
                ifb.BUSY !== (j < 32) || ifb.DONE !== (j == 32)) begin
                n_errors++;
                $display("FAIL sweep_flags step %0d: busy=%b done=%b expected %b %b",
                         j, ifa.BUSY, ifa.DONE, j < 32, j == 32);
            end
            if (j == 8) begin
                n_checks++;
                if (ifb.R[7] !== 8'h00 || ifb.R[8] !== 8'h09) begin
                    n_errors++;
                    $display("FAIL sweep_r7: R07=%h R08=%h expected 00 09", ifb.R[7], ifb.R[8]);
                end
            end
            for (int i = 0; i < NREG; i++) begin
                n_checks++;
                if (ifa.R[i] !== m_a[i] || ifb.R[i] !== m_b[i]) begin
                    n_errors++;
                    $display("FAIL sweep_R%0d step %0d: got %h/%h expected %h/%h",
                             i, j, ifa.R[i], ifb.R[i], m_a[i], m_b[i]);
                end
            end
        end
        for (int i = 0; i < NREG; i++) begin
            n_checks++;
            if (ifa.R[i] !== '0 || ifb.R[i] !== '0) begin
                n_errors++;
                $display("FAIL sweep_end_R%0d: got %h/%h expected 00", i, ifa.R[i], ifb.R[i]);
            end
        end
    endtask

    task automatic test_collision();
        step(1'b1, 5'd31, 8'h55, 1'b0);
        step(1'b1, 5'd3, 8'h3C, 1'b1);
        n_checks++;
        if (ifa.R[3] !== 8'h3C || ifb.R[3] !== 8'h3C || ifa.BUSY !== 1'b1) begin
            n_errors++;
            $display("FAIL collide_write: R03=%h/%h busy=%b expected 3c 1", ifa.R[3], ifb.R[3], ifa.BUSY);
        end
        for (int j = 1; j <= 33; j++) begin
            if (j == 10) step(1'b1, 5'd31, 8'h77, 1'b0);
            else         step(1'b0, 5'd0, '0, 1'b0);
            if (j == 3 || j == 4) begin
                n_checks++;
                if (ifb.R[3] !== ((j == 4) ? 8'h00 : 8'h3C)) begin
                    n_errors++;
                    $display("FAIL collide_clear step %0d: R03=%h expected %h", j, ifb.R[3], (j == 4) ? 8'h00 : 8'h3C);
                end
            end
            if (j == 10) begin
                n_checks++;
                if (ifa.R[31] !== 8'h55 || ifb.R[31] !== 8'h55) begin
                    n_errors++;
                    $display("FAIL drop_write: R31=%h/%h expected 55", ifa.R[31], ifb.R[31]);
                end
            end
        end
        n_checks++;
        if (ifa.R[31] !== 8'h00 || ifb.R[31] !== 8'h00 || ifa.BUSY !== 1'b0 || ifa.DONE !== 1'b0) begin
            n_errors++;
            $display("FAIL drop_after_fin: R31=%h/%h busy=%b done=%b expected 00 0 0",
                     ifa.R[31], ifb.R[31], ifa.BUSY, ifa.DONE);
        end
    endtask

    task automatic test_clr_held();
        for (int j = 1; j <= 35; j++) begin
            step(1'b1, 5'(j), 8'(j), 1'b1);
            n_checks++;
            if (ifa.BUSY !== (m_left > 0) || ifa.DONE !== m_fin || ifb.BUSY !== (m_left > 0) || ifb.DONE !== m_fin) begin
                n_errors++;
                $display("FAIL clr_held step %0d: busy=%b done=%b expected %b %b", j, ifa.BUSY, ifa.DONE, m_left > 0, m_fin);
            end
            if (j == 34 || j == 35) begin
                n_checks++;
                if (ifa.BUSY !== (j == 35) || ifa.DONE !== 1'b0) begin
                    n_errors++;
                    $display("FAIL clr_restart step %0d: busy=%b done=%b expected %b 0", j, ifa.BUSY, ifa.DONE, j == 35);
                end
            end
        end
        for (int j = 0; j < 33; j++) step(1'b0, 5'd0, '0, 1'b0);
        n_checks++;
        if (ifa.BUSY !== 1'b0 || ifa.DONE !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_held_idle: busy=%b done=%b expected 0 0", ifa.BUSY, ifa.DONE);
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < NREG; i++) step(1'b1, 5'(i), 8'($urandom_range(1, 255)), 1'b0);
        step(1'b0, 5'd0, '0, 1'b1);
        for (int j = 0; j < 10; j++) step(1'b0, 5'd0, '0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (ifa.BUSY !== 1'b0 || ifa.DONE !== 1'b0 || ifb.BUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_flags: busy=%b/%b done=%b expected 0", ifa.BUSY, ifb.BUSY, ifa.DONE);
        end
        for (int i = 0; i < NREG; i++) begin
            n_checks++;
            if (ifa.R[i] !== '0 || ifb.R[i] !== '0) begin
                n_errors++;
                $display("FAIL midreset_R%0d: got %h/%h expected 00", i, ifa.R[i], ifb.R[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5'd2, 8'h5A, 1'b0);
        n_checks++;
        if (ifa.R[2] !== 8'h5A || ifb.R[2] !== 8'h5A || ifa.BUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_write: R02=%h/%h busy=%b expected 5a 0", ifa.R[2], ifb.R[2], ifa.BUSY);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), ($urandom_range(0, 24) == 0));
            n_checks++;
            if (ifa.BUSY !== (m_left > 0) || ifa.DONE !== m_fin || ifb.BUSY !== (m_left > 0) || ifb.DONE !== m_fin) begin
                n_errors++;
                $display("FAIL random_flags cyc %0d: busy=%b done=%b expected %b %b", c, ifa.BUSY, ifa.DONE, m_left > 0, m_fin);
            end
            for (int i = 0; i < NREG; i++) begin
                n_checks++;
                if (ifa.R[i] !== m_a[i] || ifb.R[i] !== m_b[i]) begin
                    n_errors++;
                    $display("FAIL random_R%0d cyc %0d: got %h/%h expected %h/%h",
                             i, c, ifa.R[i], ifb.R[i], m_a[i], m_b[i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        drive(1'b0, 5'd0, '0, 1'b0);
        test_reset();
        test_write();
        test_r0_guard();
        test_sweep();
        test_collision();
        test_clr_held();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/register_bank32.md
# register_bank32

Storage stage that directly feeds the CPU's 32-way N-bit register read mux. It holds 32 N-bit general registers and presents all of them in parallel on R00..R31, one output per mux input, so the mux select alone chooses the read operand. It has one synchronous write port. A clear sequencer zeroes the bank one register per cycle, with a BUSY/DONE handshake, on request from the control unit.

## Interface
Parameters:
- n, default 8, width of each register and of WD / Rxx.
- ZERO_R0, default 1: when 1, R00 is hard-wired to 0 and writes to index 0 are discarded.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- WE  input  1  write enable.
- WS  input  5  write select (register index 0..31).
- WD  input  n  write data.
- CLR  input  1  clear-bank request, level-sampled in IDLE only.
- BUSY  output  1  high while the sweep is in progress.
- DONE  output  1  one-cycle pulse after the last register is cleared.
- R00..R31  output  n each  registered contents of registers 0..31, wired straight to the read mux inputs I00..I31.

## Operation
- Reset (rst_n low, async): all 32 registers = 0, state IDLE, sweep pointer P = 0, BUSY = 0, DONE = 0.
- States: IDLE, SWEEP, FIN.
- IDLE:
  - If WE is high, reg[WS] <= WD.
  - If CLR is high, go to SWEEP with P = 0.
  - If both are high in the same cycle, the write is performed and the sweep still starts. The written value is later overwritten by the sweep.
- SWEEP:
  - Each edge: reg[P] <= 0 and P <= P + 1.
  - When P == 31, the edge clears reg[31], sets P = 0 and goes to FIN.
  - WE is ignored; writes are dropped, not queued.
  - CLR is ignored.
- FIN: lasts one cycle, then returns to IDLE. WE and CLR are ignored.
- BUSY = (state == SWEEP). DONE = (state == FIN). Both are decoded from registered state, so neither has combinational input paths.
- ZERO_R0 = 1: reg[0] is never written; R00 is the constant 0.
- P is 5 bits. The SWEEP→FIN transition is decided by P == 31, not by wrap-around.
- Reset mid-sweep: immediate return to the reset state. Registers already cleared stay 0, and the rest are also forced to 0 by reset.

## Timing
- Write latency: WE sampled at edge k; the new value appears on R[WS] after edge k; the mux sees it in cycle k+1.
- There is no write-to-read bypass. A same-cycle read through the mux returns the old value.
- Clear, with CLR sampled at edge k:
  - BUSY rises after edge k.
  - reg[i] is cleared at edge k+1+i.
  - BUSY falls and DONE rises after edge k+32.
  - DONE falls and the block is back in IDLE after edge k+33.
  - Total: 33 cycles from request to accepting writes again.
- CLR held high continuously: a new sweep starts on the first IDLE cycle, i.e. after edge k+33 with BUSY high again after edge k+34.

## Structure
- Package regbank_pkg holds:
  - NREG = 32.
  - IDX_W = 5.
  - State enum {IDLE, SWEEP, FIN} with 2-bit encoding.
- Sub-module Decoder5to32: 5-bit index to 32-bit one-hot. It is shared by the write path (WS) and the sweep path (P); the select between WS and P is driven by state.
- Storage is 32 n-bit registers, each with its own enable and next-value mux (WD or 0).

## Test plan
- Reset then write: pulse rst_n low mid-cycle, then write WE=1, WS=5, WD=0xA5 → R05 = 0xA5 one cycle later; all other Rxx = 0.
- R0 guard: with ZERO_R0 = 1, write WS=0, WD=0xFF → R00 stays 0x00. With ZERO_R0 = 0, the same write gives R00 = 0xFF.
- Full sweep: load reg i = i+1 for all i, then pulse CLR at edge k:
  - BUSY is high from k to k+32.
  - reg 7 = 0 after edge k+8.
  - DONE is high for exactly one cycle after edge k+32.
  - All Rxx = 0 at the end.
- Collision and ignore: in IDLE, assert CLR and WE (WS=3, WD=0x3C) together → R03 = 0x3C after edge k, then 0 after edge k+4. A write to WS=31 during SWEEP is dropped, so R31 = 0 after FIN.
- Reset mid-sweep: assert rst_n low at sweep step 10 → BUSY and DONE drop immediately and all Rxx = 0. After release, a write to WS=2 is accepted on the next edge.
